// File: rtl/sieve_mem_pkg.sv
// Shared types for the prime-sieve bitmap controller: FSM states, read owners
// and the tag that travels alongside each read through the latency pipe.
package sieve_mem_pkg;
  localparam int AW_DEF = 20;

  typedef enum logic {INIT, RUN} state_e;
  typedef enum logic {OWN_S, OWN_Q} owner_e;

  typedef struct packed {
    owner_e owner;
    logic   oor;
    logic   byp;
    logic   byp_data;
  } rd_tag_t;
endpackage

// File: rtl/sieve_rd_arb.sv
// Two-way round-robin read arbiter; the pointer only moves on contested cycles.
module sieve_rd_arb
  import sieve_mem_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic s_req,
  input  logic q_req,
  output logic s_gnt,
  output logic q_gnt
);
  owner_e ptr_q, ptr_d;

  always_comb begin
    s_gnt = 1'b0;
    q_gnt = 1'b0;
    ptr_d = ptr_q;
    if (en) begin
      if (s_req && q_req) begin
        if (ptr_q == OWN_S) begin
          s_gnt = 1'b1;
          ptr_d = OWN_Q;
        end else begin
          q_gnt = 1'b1;
          ptr_d = OWN_S;
        end
      end else begin
        s_gnt = s_req;
        q_gnt = q_req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= OWN_S;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/sieve_mem_ctrl.sv
// Owns the 1-bit sieve bitmap RAM: initialises it, then shares it between the
// sieve engine and a query client. SIEVE_MEM_STATS_EN adds saturating counters.
module sieve_mem_ctrl
  import sieve_mem_pkg::*;
#(
  parameter int N      = 1000000,
  parameter int AW     = AW_DEF,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  output logic          init_done,
  input  logic          s_rd_req,
  input  logic [AW-1:0] s_rd_addr,
  output logic          s_rd_gnt,
  output logic          s_rd_valid,
  output logic          s_rd_data,
  input  logic          s_wr_req,
  input  logic [AW-1:0] s_wr_addr,
  input  logic          s_wr_data,
  output logic          s_wr_gnt,
  input  logic          q_rd_req,
  input  logic [AW-1:0] q_rd_addr,
  output logic          q_rd_gnt,
  output logic          q_rd_valid,
  output logic          q_rd_data,
  output logic          ram_wea,
  output logic [AW-1:0] ram_waddr,
  output logic          ram_wdata,
  output logic [AW-1:0] ram_raddr,
  input  logic          ram_rdata
`ifdef SIEVE_MEM_STATS_EN
  ,
  output logic [31:0]   stat_q_grants,
  output logic [31:0]   stat_s_stalls,
  output logic [31:0]   stat_collisions
`endif
);
  localparam logic [AW:0]   N_W  = (AW+1)'(N);
  localparam logic [AW-1:0] LAST = AW'(N-1);

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              ram_wea_q, ram_wea_d, ram_wdata_q, ram_wdata_d;
  logic [AW-1:0]     ram_waddr_q, ram_waddr_d, ram_raddr_q, ram_raddr_d;
  logic [RD_LAT:0]   vld_pipe_q, vld_pipe_d;
  rd_tag_t [RD_LAT:0] tag_pipe_q, tag_pipe_d;

  logic          run, rd_acc, rd_oor, wr_oor, collide, rd_bit;
  logic [AW-1:0] rd_addr;
  rd_tag_t       tag_in, tag_out;

  // Grants only once the last init write is visible and never in a clr cycle.
  assign run = init_done_q && !clr;

  sieve_rd_arb u_arb (
    .clk   (clk),
    .rst_n (rstn),
    .en    (run),
    .s_req (s_rd_req),
    .q_req (q_rd_req),
    .s_gnt (s_rd_gnt),
    .q_gnt (q_rd_gnt)
  );

  assign s_wr_gnt = run && s_wr_req;
  assign rd_acc   = s_rd_gnt || q_rd_gnt;
  assign rd_addr  = q_rd_gnt ? q_rd_addr : s_rd_addr;
  assign rd_oor   = {1'b0, rd_addr} >= N_W;
  assign wr_oor   = {1'b0, s_wr_addr} >= N_W;
  // The RAM reads the old value when written in the same edge, so forward it.
  assign collide  = s_wr_gnt && !wr_oor && rd_acc && !rd_oor && (s_wr_addr == rd_addr);
  assign tag_in   = '{owner: (q_rd_gnt ? OWN_Q : OWN_S), oor: rd_oor,
                      byp: collide, byp_data: s_wr_data};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_wea_d   = 1'b0;
    ram_waddr_d = ram_waddr_q;
    ram_wdata_d = ram_wdata_q;
    ram_raddr_d = ram_raddr_q;
    if (clr) begin
      state_d = INIT;
      cnt_d   = '0;
    end else if (state_q == INIT) begin
      ram_wea_d   = 1'b1;
      ram_waddr_d = cnt_q;
      ram_wdata_d = |cnt_q[AW-1:1];
      cnt_d       = cnt_q + 1'b1;
      if (cnt_q == LAST) state_d = RUN;
    end else if (s_wr_gnt) begin
      ram_wea_d   = !wr_oor;
      ram_waddr_d = s_wr_addr;
      ram_wdata_d = s_wr_data;
    end
    if (rd_acc) ram_raddr_d = rd_addr;
    init_done_d = (state_q == RUN) && (state_d == RUN);
    vld_pipe_d  = {vld_pipe_q[RD_LAT-1:0], rd_acc};
    tag_pipe_d  = {tag_pipe_q[RD_LAT-1:0], tag_in};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      ram_wea_q   <= 1'b0;
      ram_waddr_q <= '0;
      ram_wdata_q <= 1'b0;
      ram_raddr_q <= '0;
      vld_pipe_q  <= '0;
      tag_pipe_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      ram_wea_q   <= ram_wea_d;
      ram_waddr_q <= ram_waddr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_raddr_q <= ram_raddr_d;
      vld_pipe_q  <= vld_pipe_d;
      tag_pipe_q  <= tag_pipe_d;
    end
  end

  assign tag_out    = tag_pipe_q[RD_LAT];
  assign rd_bit     = tag_out.oor ? 1'b0 : (tag_out.byp ? tag_out.byp_data : ram_rdata);
  assign s_rd_valid = vld_pipe_q[RD_LAT] && (tag_out.owner == OWN_S);
  assign q_rd_valid = vld_pipe_q[RD_LAT] && (tag_out.owner == OWN_Q);
  assign s_rd_data  = s_rd_valid && rd_bit;
  assign q_rd_data  = q_rd_valid && rd_bit;
  assign init_done  = init_done_q;
  assign ram_wea    = ram_wea_q;
  assign ram_waddr  = ram_waddr_q;
  assign ram_wdata  = ram_wdata_q;
  assign ram_raddr  = ram_raddr_q;

`ifdef SIEVE_MEM_STATS_EN
  logic [31:0] qg_q, qg_d, st_q, st_d, co_q, co_d;

  always_comb begin
    qg_d = qg_q;
    st_d = st_q;
    co_d = co_q;
    if (clr) begin
      qg_d = '0;
      st_d = '0;
      co_d = '0;
    end else begin
      if (q_rd_gnt && (qg_q != '1))                    qg_d = qg_q + 1'b1;
      if (run && s_rd_req && !s_rd_gnt && (st_q != '1)) st_d = st_q + 1'b1;
      if (collide && (co_q != '1))                     co_d = co_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      qg_q <= '0;
      st_q <= '0;
      co_q <= '0;
    end else begin
      qg_q <= qg_d;
      st_q <= st_d;
      co_q <= co_d;
    end
  end

  assign stat_q_grants   = qg_q;
  assign stat_s_stalls   = st_q;
  assign stat_collisions = co_q;
`endif
endmodule
